commit_ctrl: RTL and testbench

Sequencing controller for the commit datapath of the out-of-order core. It watches the ROB head and decides each cycle whether the head retires. Non-store instructions retire in zero cycles. Committed stores go through a request/grant/done handshake with the data-memory port, and their ROB entry is held until the write completes. It also latches the halt condition and keeps a count of retired instructions.

---
 rtl/commit_ctrl.sv | 161 ++++++++++++++++
 tb/tb_commit_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_ctrl.sv
// commit_ctrl
//   Sequences retirement of the ROB head. ALU-type heads retire in the same
//   cycle they are valid and ready. Stores are latched and pushed through a
//   request/grant/done handshake with the data-memory port. The ROB entry is
//   not popped until the write is done. A retired halt parks the block in an
//   absorbing state until reset.
//
// Ports
//   clock_i, reset_i        clock (rising edge), async active-high reset
//   head_*_i                ROB head entry: valid/ready/store/halt flags,
//                           store address/data/size and ROB tag
//   flush_i                 mispredict squash; only honoured in RUN
//   mem_grant_i, mem_done_i memory port accept / write-complete
//   retire_o, retire_tag_o  pop ROB head this cycle, and the tag popped
//   mem_req_o, mem_*_o      store request and its latched payload
//   busy_o                  store sequence in flight
//   halted_o                halt has retired
//   retired_count_o         running count of retire pulses (wraps)
module commit_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 64
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             head_valid_i,
    input  logic             head_ready_i,
    input  logic             head_wr_mem_i,
    input  logic             head_halt_i,
    input  logic [XLEN-1:0]  head_addr_i,
    input  logic [XLEN-1:0]  head_value_i,
    input  logic [1:0]       head_size_i,
    input  logic [TAG_W-1:0] head_tag_i,
    input  logic             flush_i,
    input  logic             mem_grant_i,
    input  logic             mem_done_i,
    output logic             retire_o,
    output logic [TAG_W-1:0] retire_tag_o,
    output logic             mem_req_o,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_data_o,
    output logic [1:0]       mem_size_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_count_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        HALTED  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    data_q, data_d;
    logic [1:0]         size_q, size_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               retire;
    logic               hit;

    // A squash in the same cycle wins over retirement of the head.
    assign hit = head_valid_i & head_ready_i & ~flush_i;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        tag_d   = tag_q;
        retire  = 1'b0;

        unique case (state_q)
            RUN: begin
                if (hit) begin
                    // Halt is checked first so a halt that also carries the
                    // store flag never reaches the memory port.
                    if (head_halt_i) begin
                        retire  = 1'b1;
                        state_d = HALTED;
                    end else if (head_wr_mem_i) begin
                        addr_d  = head_addr_i;
                        data_d  = head_value_i;
                        size_d  = head_size_i;
                        tag_d   = head_tag_i;
                        state_d = ST_REQ;
                    end else begin
                        retire  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // Store is committed; flush is deliberately not looked at.
                if (mem_grant_i) begin
                    if (mem_done_i) begin
                        retire  = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_done_i) begin
                    retire  = 1'b1;
                    state_d = RUN;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign count_d = retire ? (count_q + CNT_W'(1)) : count_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= RUN;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            tag_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            tag_q   <= tag_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign retire_o        = retire;
    // In RUN the head itself retires; in the store states the popped entry
    // is the one captured when the store was accepted.
    assign retire_tag_o    = (state_q == RUN) ? head_tag_i : tag_q;
    assign mem_req_o       = (state_q == ST_REQ);
    assign mem_addr_o      = addr_q;
    assign mem_data_o      = data_q;
    assign mem_size_o      = size_q;
    assign busy_o          = (state_q == ST_REQ) | (state_q == ST_WAIT);
    assign halted_o        = (state_q == HALTED);
    assign retired_count_o = count_q;

endmodule

// File: tb/tb_commit_ctrl.sv
module tb_commit_ctrl;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int CNT_W = 64;

    logic             clock, reset;
    logic             head_valid, head_ready, head_wr_mem, head_halt;
    logic [XLEN-1:0]  head_addr, head_value;
    logic [1:0]       head_size;
    logic [TAG_W-1:0] head_tag;
    logic             flush, mem_grant, mem_done;
    logic             retire, mem_req, busy, halted;
    logic [TAG_W-1:0] retire_tag;
    logic [XLEN-1:0]  mem_addr, mem_data;
    logic [1:0]       mem_size;
    logic [CNT_W-1:0] retired_count;

    commit_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clock_i(clock), .reset_i(reset),
        .head_valid_i(head_valid), .head_ready_i(head_ready),
        .head_wr_mem_i(head_wr_mem), .head_halt_i(head_halt),
        .head_addr_i(head_addr), .head_value_i(head_value),
        .head_size_i(head_size), .head_tag_i(head_tag),
        .flush_i(flush), .mem_grant_i(mem_grant), .mem_done_i(mem_done),
        .retire_o(retire), .retire_tag_o(retire_tag),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .mem_size_o(mem_size), .busy_o(busy), .halted_o(halted),
        .retired_count_o(retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             retire;
        logic             chk_tag;
        logic [TAG_W-1:0] tag;
        logic             mem_req;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
        logic [1:0]       size;
        logic             busy;
        logic             halted;
        logic [CNT_W-1:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   stim_done  = 0;

    // Reference model: what the commit stage owes the world, tracked as
    // "is a store outstanding, has it been accepted, has a halt retired".
    bit               m_store_out;   // a committed store has not finished
    bit               m_accepted;    // memory port has granted it
    bit               m_halted;
    logic [XLEN-1:0]  m_addr, m_data;
    logic [1:0]       m_size;
    logic [TAG_W-1:0] m_tag;
    longint unsigned  m_retired;

    task automatic model_reset();
        m_store_out = 0; m_accepted = 0; m_halted = 0;
        m_addr = '0; m_data = '0; m_size = '0; m_tag = '0; m_retired = 0;
    endtask

    // Apply one cycle of inputs, predict the visible outputs, advance model.
    task automatic step(input bit rst, input bit v, input bit r, input bit wr,
                        input bit h, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] d, input logic [1:0] sz,
                        input logic [TAG_W-1:0] t, input bit fl,
                        input bit g, input bit dn);
        exp_t e;
        bit   ret;
        @(posedge clock);
        #1;
        reset = rst; head_valid = v; head_ready = r; head_wr_mem = wr;
        head_halt = h; head_addr = a; head_value = d; head_size = sz;
        head_tag = t; flush = fl; mem_grant = g; mem_done = dn;
        if (rst) model_reset();
        ret = 0;
        e.chk_tag = !m_halted;
        e.tag     = m_store_out ? m_tag : t;
        e.mem_req = m_store_out && !m_accepted;
        e.addr = m_addr; e.data = m_data; e.size = m_size;
        e.busy = m_store_out; e.halted = m_halted;
        e.count = CNT_W'(m_retired);
        if (!rst && !m_halted) begin
            if (m_store_out) begin
                if ((m_accepted || g) && dn) begin
                    ret = 1; m_store_out = 0; m_accepted = 0;
                end else if (g) begin
                    m_accepted = 1;
                end
            end else if (v && r && !fl) begin
                if (h) begin
                    ret = 1; m_halted = 1;
                end else if (wr) begin
                    m_store_out = 1; m_accepted = 0;
                    m_addr = a; m_data = d; m_size = sz; m_tag = t;
                end else begin
                    ret = 1;
                end
            end
        end
        e.retire = ret;
        if (ret) m_retired++;
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit g = 0, input bit dn = 0, input bit fl = 0);
        step(0, 0, 0, 0, 0, '0, '0, 2'd0, '0, fl, g, dn);
    endtask

    task automatic alu(input logic [TAG_W-1:0] t, input bit fl = 0);
        step(0, 1, 1, 0, 0, $urandom, $urandom, 2'($urandom), t, fl, 0, 0);
    endtask

    // Monitor: one expected entry per driven cycle, checked mid-cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (retire !== e.retire) begin
                miscompares++;
                $display("FAIL retire t=%0t got %b want %b", $time, retire, e.retire);
            end
            if (e.chk_tag && retire_tag !== e.tag) begin
                miscompares++;
                $display("FAIL retire_tag t=%0t got %0d want %0d", $time, retire_tag, e.tag);
            end
            if (mem_req !== e.mem_req) begin
                miscompares++;
                $display("FAIL mem_req t=%0t got %b want %b", $time, mem_req, e.mem_req);
            end
            if (mem_addr !== e.addr || mem_data !== e.data || mem_size !== e.size) begin
                miscompares++;
                $display("FAIL mem_payload t=%0t got %h/%h/%0d want %h/%h/%0d", $time,
                         mem_addr, mem_data, mem_size, e.addr, e.data, e.size);
            end
            if (busy !== e.busy) begin
                miscompares++;
                $display("FAIL busy t=%0t got %b want %b", $time, busy, e.busy);
            end
            if (halted !== e.halted) begin
                miscompares++;
                $display("FAIL halted t=%0t got %b want %b", $time, halted, e.halted);
            end
            if (retired_count !== e.count) begin
                miscompares++;
                $display("FAIL retired_count t=%0t got %0d want %0d", $time, retired_count, e.count);
            end
        end
    end

    initial begin
        reset = 1; head_valid = 0; head_ready = 0; head_wr_mem = 0; head_halt = 0;
        head_addr = '0; head_value = '0; head_size = '0; head_tag = '0;
        flush = 0; mem_grant = 0; mem_done = 0;
        model_reset();
        step(1, 0, 0, 0, 0, '0, '0, 2'd0, '0, 0, 0, 0);
        step(1, 0, 0, 0, 0, '0, '0, 2'd0, '0, 0, 0, 0);

        // Three ALU heads back to back.
        alu(1); alu(2); alu(3); idle();

        // Store tag 4, grant held off 3 cycles, done 2 cycles after grant.
        step(0, 1, 1, 1, 0, 32'h100, 32'hDEADBEEF, 2'd2, 5'd4, 0, 0, 0);
        idle(); idle(); idle();
        idle(1, 0);
        idle(); idle(0, 1);
        alu(7);

        // Store with grant+done on the first request cycle.
        step(0, 1, 1, 1, 0, 32'h200, 32'h12345678, 2'd1, 5'd9, 0, 0, 0);
        idle(1, 1);
        alu(10);

        // Flush blocks an ALU head; flush in the wait phase is ignored.
        alu(11, 1);
        step(0, 1, 1, 1, 0, 32'h300, 32'hCAFEF00D, 2'd0, 5'd12, 0, 0, 0);
        idle(1, 0);
        idle(0, 0, 1);
        idle(0, 1, 1);

        // Reset mid request, then normal retire.
        step(0, 1, 1, 1, 0, 32'h400, 32'hA5A5A5A5, 2'd2, 5'd13, 0, 0, 0);
        idle();
        step(1, 0, 0, 0, 0, '0, '0, 2'd0, '0, 0, 0, 0);
        alu(14); alu(15);

        // Halt, then everything else is ignored.
        step(0, 1, 1, 0, 1, '0, '0, 2'd0, 5'd16, 0, 0, 0);
        alu(17);
        step(0, 1, 1, 1, 0, 32'h500, 32'h1, 2'd0, 5'd18, 0, 1, 1);
        idle(1, 1);
        step(1, 0, 0, 0, 0, '0, '0, 2'd0, '0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            rst = ($urandom_range(0, 299) == 0) || (m_halted && $urandom_range(0, 7) == 0);
            if (rst)
                step(1, 0, 0, 0, 0, '0, '0, 2'd0, '0, 0, 0, 0);
            else
                step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0,
                     $urandom, $urandom, 2'($urandom), 5'($urandom),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0);
        end
        stim_done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 100) begin
            @(posedge clock);
            budget++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain left %0d want 0", exp_q.size());
        end
        @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end
endmodule
